// File: rtl/dmem_responder.sv
// Data-memory responder for the MIPS32 MEM stage: services loads/stores after LATENCY stall cycles.
// Optional misaligned-access trap is enabled by defining DMEM_ALIGN_CHECK_EN.
//
// state  | meaning
// S_IDLE | no access in flight; accepts a new request (completes at once when LATENCY=0)
// S_WAIT | access accepted, counting down stall cycles; completes when cnt reaches 0
module dmem_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
`ifdef DMEM_ALIGN_CHECK_EN
    output logic        addr_err,
`endif
    output logic        mem_stall
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    localparam int LAT_M1 = (LATENCY > 0) ? LATENCY - 1 : 0;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [31:0]             mem_q [0:(1<<DEPTH_LOG2)-1];
    logic [DEPTH_LOG2-1:0]   idx;
    logic                    req;
    logic                    misal;
    logic                    complete;
    logic                    we;
    logic                    unused_addr;

    assign req         = mem_read | mem_write;
    assign idx         = addr[DEPTH_LOG2+1:2];
    assign unused_addr = ^{addr[31:DEPTH_LOG2+2], addr[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
    assign misal    = req & (addr[1:0] != 2'b00);
    assign addr_err = misal & ~reset;
`else
    assign misal = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The array is deliberately outside the reset domain so reset never clears it.
    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[idx] <= wdata;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_stall = 1'b0;
        complete  = 1'b0;
        if (!reset) begin
            if (misal) begin
                state_d = S_IDLE;
            end else if (state_q == S_IDLE) begin
                if (req) begin
                    if (LATENCY == 0) begin
                        complete = 1'b1;
                    end else begin
                        mem_stall = 1'b1;
                        state_d   = S_WAIT;
                        cnt_d     = 4'(LAT_M1);
                    end
                end
            end else begin
                if (!req) begin
                    state_d = S_IDLE;
                end else if (cnt_q != 4'd0) begin
                    mem_stall = 1'b1;
                    cnt_d     = cnt_q - 4'd1;
                end else begin
                    complete = 1'b1;
                    state_d  = S_IDLE;
                end
            end
        end
    end

    // Write wins when both request bits are set, so a read is only a pure mem_read.
    always_comb begin
        we    = complete & mem_write;
        rdata = 32'h0;
        if (complete && mem_read && !mem_write) begin
            rdata = mem_q[idx];
        end
    end

endmodule
